// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALU encodings and per-stage control bundles for the control pipeline.
package ctrl_pkg;

  localparam logic [7:0] OP_ADD   = 8'h8A;
  localparam logic [7:0] OP_SUBCC = 8'h86;
  localparam logic [7:0] OP_LDUB  = 8'hC4;
  localparam logic [7:0] OP_STB   = 8'hCA;
  localparam logic [7:0] OP_BNE   = 8'h12;
  localparam logic [7:0] OP_SETHI = 8'h0B;
  localparam logic [7:0] OP_CALL  = 8'h40;
  localparam logic [7:0] OP_JMPL  = 8'h81;
  localparam logic [7:0] OP_NOP   = 8'h00;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_PASS = 4'd5;

  // EX bundle also carries the MEM/WB controls that ride along behind it.
  typedef struct packed {
    logic        valid;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        branch;
    logic        call;
    logic        jmpl;
    logic        link;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } ex_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } mem_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } wb_ctrl_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Fetch/datapath-facing signal bundle of the control pipeline.
interface ctrl_pipe_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [31:0]      instr;
  logic             stall_ext;
  logic             br_taken_EX;
  logic             id_ready;
  logic             redirect;
  logic             ex_valid;
  logic [3:0]       ex_alu_op;
  logic             ex_alu_src;
  logic             ex_branch;
  logic             ex_call;
  logic             ex_jmpl;
  logic             ex_link;
  logic [31:0]      ex_imm;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic [4:0]       ex_rd;
  logic             mem_valid;
  logic             mem_read;
  logic             mem_write;
  logic [4:0]       mem_rd;
  logic             wb_valid;
  logic             wb_reg_write;
  logic             wb_mem_to_reg;
  logic [4:0]       wb_rd;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] unk_cnt;

  // Fetch/datapath side.
  modport master (
    output id_valid, instr, stall_ext, br_taken_EX,
    input  id_ready, redirect,
    input  ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_call, ex_jmpl, ex_link,
    input  ex_imm, ex_rs1, ex_rs2, ex_rd,
    input  mem_valid, mem_read, mem_write, mem_rd,
    input  wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd,
    input  retire_cnt, unk_cnt
  );

  // Control pipeline side.
  modport slave (
    input  id_valid, instr, stall_ext, br_taken_EX,
    output id_ready, redirect,
    output ex_valid, ex_alu_op, ex_alu_src, ex_branch, ex_call, ex_jmpl, ex_link,
    output ex_imm, ex_rs1, ex_rs2, ex_rd,
    output mem_valid, mem_read, mem_write, mem_rd,
    output wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd,
    output retire_cnt, unk_cnt
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-bundle decoder for the ID stage.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned IMM_W    = 16,
  parameter int unsigned LINK_REG = 15
) (
  input  logic [31:0] instr,
  output ex_ctrl_t    ctrl,
  output logic        unknown,
  output logic        uses_rs2
);

  // Decode op = instr[31:24]; unrecognised opcodes behave as nop and are flagged.
  always_comb begin
    ctrl     = '0;
    unknown  = 1'b0;
    uses_rs2 = 1'b0;
    ctrl.imm = {{(32 - IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    ctrl.rs1 = instr[23:19];
    ctrl.rs2 = instr[18:14];
    ctrl.rd  = instr[4:0];
    case (instr[31:24])
      OP_ADD: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.reg_write = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_SUBCC: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LDUB: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_STB: begin
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BNE: begin
        ctrl.branch = 1'b1;
      end
      OP_SETHI: begin
        ctrl.alu_op    = ALU_PASS;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_CALL: begin
        ctrl.call      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.rd        = 5'(LINK_REG);
      end
      OP_JMPL: begin
        ctrl.jmpl      = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_NOP: begin
      end
      default: begin
        unknown = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: ID decode, EX/MEM/WB control registers, load-use
// bubbles, redirects with optional delay-slot squash, and retire/unknown counters.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned IMM_W      = 16,
  parameter int unsigned DELAY_SLOT = 1,
  parameter int unsigned LINK_REG   = 15,
  parameter int unsigned CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  ctrl_pipe_if.slave   bus
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};

  ex_ctrl_t         dec_ctrl;
  logic             dec_unknown;
  logic             dec_uses_rs2;
  ex_ctrl_t         ex_q, ex_d;
  mem_ctrl_t        mem_q, mem_d;
  wb_ctrl_t         wb_q, wb_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] unk_q, unk_d;
  logic             hazard;
  logic             redirect;
  logic             accept;
  logic             squash;

  ctrl_decode #(
    .IMM_W    (IMM_W),
    .LINK_REG (LINK_REG)
  ) u_decode (
    .instr    (bus.instr),
    .ctrl     (dec_ctrl),
    .unknown  (dec_unknown),
    .uses_rs2 (dec_uses_rs2)
  );

  // Hazard, redirect and ID handshake; stall_ext overrides everything.
  always_comb begin
    hazard = bus.id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
             ((ex_q.rd == dec_ctrl.rs1) || (dec_uses_rs2 && (ex_q.rd == dec_ctrl.rs2)));
    redirect = !bus.stall_ext && ex_q.valid &&
               ((ex_q.branch && bus.br_taken_EX) || ex_q.call || ex_q.jmpl);
    accept = bus.id_valid && !bus.stall_ext && !hazard;
    // Without a delay slot the instruction following the redirect is dropped.
    squash = redirect && (DELAY_SLOT == 0);
  end

  // Next-state for stage registers and saturating counters.
  always_comb begin
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    retire_d = retire_q;
    unk_d    = unk_q;
    if (!bus.stall_ext) begin
      mem_d.valid      = ex_q.valid;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.mem_to_reg = ex_q.mem_to_reg;
      mem_d.rd         = ex_q.rd;
      wb_d.valid       = mem_q.valid;
      wb_d.reg_write   = mem_q.reg_write;
      wb_d.mem_to_reg  = mem_q.mem_to_reg;
      wb_d.rd          = mem_q.rd;
      ex_d             = '0;
      if (accept && !squash) begin
        ex_d       = dec_ctrl;
        ex_d.valid = 1'b1;
        if (dec_unknown && (unk_q != '1)) begin
          unk_d = unk_q + CntOne;
        end
      end
      if (wb_q.valid && (retire_q != '1)) begin
        retire_d = retire_q + CntOne;
      end
    end
  end

  // Stage and counter registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      retire_q <= '0;
      unk_q    <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      retire_q <= retire_d;
      unk_q    <= unk_d;
    end
  end

  assign bus.id_ready      = !bus.stall_ext && !hazard;
  assign bus.redirect      = redirect;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_branch     = ex_q.branch;
  assign bus.ex_call       = ex_q.call;
  assign bus.ex_jmpl       = ex_q.jmpl;
  assign bus.ex_link       = ex_q.link;
  assign bus.ex_imm        = ex_q.imm;
  assign bus.ex_rs1        = ex_q.rs1;
  assign bus.ex_rs2        = ex_q.rs2;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.mem_valid     = mem_q.valid;
  assign bus.mem_read      = mem_q.mem_read;
  assign bus.mem_write     = mem_q.mem_write;
  assign bus.mem_rd        = mem_q.rd;
  assign bus.wb_valid      = wb_q.valid;
  assign bus.wb_reg_write  = wb_q.reg_write;
  assign bus.wb_mem_to_reg = wb_q.mem_to_reg;
  assign bus.wb_rd         = wb_q.rd;
  assign bus.retire_cnt    = retire_q;
  assign bus.unk_cnt       = unk_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench: dut0 has a delay slot and 16-bit counters, dut1 squashes the
// delay slot and has 2-bit counters; both see identical stimulus.
module tb_ctrl_pipe;

  localparam logic [31:0] I_ADD    = 32'h8A08_8005; // add r5 = r1 + r2, low16 0x8005
  localparam logic [31:0] I_SETHI  = 32'h0B00_1246; // sethi r6, imm 0x1246
  localparam logic [31:0] I_STB    = 32'hCA10_0007; // stb r7 -> [r2 + imm]
  localparam logic [31:0] I_NOP    = 32'h0000_0000;
  localparam logic [31:0] I_LDUB3  = 32'hC408_0003; // ldub r3 <- [r1 + imm]
  localparam logic [31:0] I_ADDR3  = 32'h8A19_0008; // add r8 = r3 + r4
  localparam logic [31:0] I_LDUB0  = 32'hC408_0000; // ldub r0
  localparam logic [31:0] I_ADDR0  = 32'h8A00_0008; // add r8 = r0 + r0
  localparam logic [31:0] I_BNE    = 32'h1200_0000;
  localparam logic [31:0] I_CALL   = 32'h4000_0000;
  localparam logic [31:0] I_JMPL   = 32'h8100_0009; // jmpl, link into r9
  localparam logic [31:0] I_UNK    = 32'hFF00_0000;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  ctrl_pipe_if #(.CNT_W(16)) bus0 ();
  ctrl_pipe_if #(.CNT_W(2))  bus1 ();

  ctrl_pipe #(.IMM_W(16), .DELAY_SLOT(1), .LINK_REG(15), .CNT_W(16)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  ctrl_pipe #(.IMM_W(16), .DELAY_SLOT(0), .LINK_REG(15), .CNT_W(2)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] ins, input logic stl, input logic bt);
    bus0.id_valid = v;  bus0.instr = ins;  bus0.stall_ext = stl;  bus0.br_taken_EX = bt;
    bus1.id_valid = v;  bus1.instr = ins;  bus1.stall_ext = stl;  bus1.br_taken_EX = bt;
    #1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    n_cmp++; if (bus0.ex_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_ex_valid got %0h want 0", bus0.ex_valid); end
    n_cmp++; if (bus0.mem_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_mem_valid got %0h want 0", bus0.mem_valid); end
    n_cmp++; if (bus0.wb_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_wb_valid got %0h want 0", bus0.wb_valid); end
    n_cmp++; if (bus0.ex_imm !== 32'h0) begin n_bad++;
      $display("FAIL reset_ex_imm got %0h want 0", bus0.ex_imm); end
    n_cmp++; if (bus0.retire_cnt !== 16'h0 || bus0.unk_cnt !== 16'h0) begin n_bad++;
      $display("FAIL reset_counters got %0h/%0h want 0/0", bus0.retire_cnt, bus0.unk_cnt); end
    n_cmp++; if (bus0.id_ready !== 1'b1 || bus0.redirect !== 1'b0) begin n_bad++;
      $display("FAIL reset_hs got rdy=%0h rdr=%0h want 1/0", bus0.id_ready, bus0.redirect); end
  endtask

  task automatic test_stream();
    do_reset();
    drive(1'b1, I_ADD, 1'b0, 1'b0);
    cyc(); // add in EX
    n_cmp++; if (bus0.ex_valid !== 1'b1 || bus0.ex_alu_op !== 4'd0 || bus0.ex_alu_src !== 1'b0)
      begin n_bad++; $display("FAIL stream_add_ex got v=%0h op=%0h src=%0h want 1/0/0",
        bus0.ex_valid, bus0.ex_alu_op, bus0.ex_alu_src); end
    n_cmp++; if (bus0.ex_rs1 !== 5'd1 || bus0.ex_rs2 !== 5'd2 || bus0.ex_rd !== 5'd5) begin
      n_bad++; $display("FAIL stream_add_regs got %0d/%0d/%0d want 1/2/5",
        bus0.ex_rs1, bus0.ex_rs2, bus0.ex_rd); end
    n_cmp++; if (bus0.ex_imm !== 32'hFFFF_8005) begin n_bad++;
      $display("FAIL stream_add_imm got %0h want ffff8005", bus0.ex_imm); end
    drive(1'b1, I_SETHI, 1'b0, 1'b0);
    cyc(); // sethi in EX, add in MEM
    n_cmp++; if (bus0.ex_alu_op !== 4'd5 || bus0.ex_alu_src !== 1'b1 ||
                 bus0.ex_imm !== 32'h0000_1246) begin n_bad++;
      $display("FAIL stream_sethi_ex got op=%0h src=%0h imm=%0h want 5/1/1246",
        bus0.ex_alu_op, bus0.ex_alu_src, bus0.ex_imm); end
    n_cmp++; if (bus0.mem_valid !== 1'b1 || bus0.mem_rd !== 5'd5) begin n_bad++;
      $display("FAIL stream_add_mem got v=%0h rd=%0d want 1/5", bus0.mem_valid, bus0.mem_rd); end
    drive(1'b1, I_STB, 1'b0, 1'b0);
    cyc(); // add in WB
    n_cmp++; if (bus0.wb_valid !== 1'b1 || bus0.wb_reg_write !== 1'b1 || bus0.wb_rd !== 5'd5)
      begin n_bad++; $display("FAIL stream_add_wb got v=%0h rw=%0h rd=%0d want 1/1/5",
        bus0.wb_valid, bus0.wb_reg_write, bus0.wb_rd); end
    drive(1'b1, I_NOP, 1'b0, 1'b0);
    cyc(); // nop EX, stb MEM, sethi WB
    n_cmp++; if (bus0.mem_write !== 1'b1 || bus0.mem_rd !== 5'd7) begin n_bad++;
      $display("FAIL stream_stb_mem got mw=%0h rd=%0d want 1/7", bus0.mem_write, bus0.mem_rd); end
    n_cmp++; if (bus0.wb_reg_write !== 1'b1 || bus0.wb_rd !== 5'd6) begin n_bad++;
      $display("FAIL stream_sethi_wb got rw=%0h rd=%0d want 1/6", bus0.wb_reg_write, bus0.wb_rd); end
    n_cmp++; if (bus0.retire_cnt !== 16'd1) begin n_bad++;
      $display("FAIL stream_retire_e4 got %0d want 1", bus0.retire_cnt); end
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    cyc(); // stb WB
    n_cmp++; if (bus0.wb_valid !== 1'b1 || bus0.wb_reg_write !== 1'b0) begin n_bad++;
      $display("FAIL stream_stb_wb got v=%0h rw=%0h want 1/0", bus0.wb_valid, bus0.wb_reg_write); end
    cyc();
    cyc();
    n_cmp++; if (bus0.retire_cnt !== 16'd4) begin n_bad++;
      $display("FAIL stream_retire got %0d want 4", bus0.retire_cnt); end
    n_cmp++; if (bus1.retire_cnt !== 2'd3) begin n_bad++;
      $display("FAIL stream_retire_sat got %0d want 3", bus1.retire_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, I_LDUB3, 1'b0, 1'b0);
    cyc(); // ldub in EX
    drive(1'b1, I_ADDR3, 1'b0, 1'b0);
    n_cmp++; if (bus0.id_ready !== 1'b0) begin n_bad++;
      $display("FAIL lu_ready_low got %0h want 0", bus0.id_ready); end
    cyc(); // bubble in EX
    n_cmp++; if (bus0.ex_valid !== 1'b0 || bus0.mem_read !== 1'b1 || bus0.mem_rd !== 5'd3) begin
      n_bad++; $display("FAIL lu_bubble got exv=%0h mr=%0h mrd=%0d want 0/1/3",
        bus0.ex_valid, bus0.mem_read, bus0.mem_rd); end
    n_cmp++; if (bus0.id_ready !== 1'b1) begin n_bad++;
      $display("FAIL lu_ready_back got %0h want 1", bus0.id_ready); end
    cyc(); // add in EX, ldub in WB
    n_cmp++; if (bus0.ex_valid !== 1'b1 || bus0.ex_rd !== 5'd8) begin n_bad++;
      $display("FAIL lu_add_ex got v=%0h rd=%0d want 1/8", bus0.ex_valid, bus0.ex_rd); end
    n_cmp++; if (bus0.wb_mem_to_reg !== 1'b1 || bus0.wb_rd !== 5'd3) begin n_bad++;
      $display("FAIL lu_ld_wb got m2r=%0h rd=%0d want 1/3", bus0.wb_mem_to_reg, bus0.wb_rd); end
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    cyc();
    n_cmp++; if (bus0.wb_valid !== 1'b0) begin n_bad++;
      $display("FAIL lu_wb_bubble got %0h want 0", bus0.wb_valid); end
    cyc();
    n_cmp++; if (bus0.wb_valid !== 1'b1 || bus0.wb_rd !== 5'd8) begin n_bad++;
      $display("FAIL lu_add_wb got v=%0h rd=%0d want 1/8", bus0.wb_valid, bus0.wb_rd); end
    // Load into r0 never creates a dependency.
    do_reset();
    drive(1'b1, I_LDUB0, 1'b0, 1'b0);
    cyc();
    drive(1'b1, I_ADDR0, 1'b0, 1'b0);
    n_cmp++; if (bus0.id_ready !== 1'b1) begin n_bad++;
      $display("FAIL lu_r0_ready got %0h want 1", bus0.id_ready); end
    cyc();
    n_cmp++; if (bus0.ex_valid !== 1'b1 || bus0.ex_rd !== 5'd8) begin n_bad++;
      $display("FAIL lu_r0_ex got v=%0h rd=%0d want 1/8", bus0.ex_valid, bus0.ex_rd); end
  endtask

  task automatic test_redirect();
    do_reset();
    drive(1'b1, I_BNE, 1'b0, 1'b0);
    cyc();
    drive(1'b1, I_ADD, 1'b0, 1'b0);
    n_cmp++; if (bus0.redirect !== 1'b0) begin n_bad++;
      $display("FAIL bne_not_taken got %0h want 0", bus0.redirect); end
    drive(1'b1, I_ADD, 1'b0, 1'b1);
    n_cmp++; if (bus0.redirect !== 1'b1 || bus1.redirect !== 1'b1) begin n_bad++;
      $display("FAIL bne_redirect got %0h/%0h want 1/1", bus0.redirect, bus1.redirect); end
    cyc();
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    n_cmp++; if (bus0.redirect !== 1'b0) begin n_bad++;
      $display("FAIL bne_pulse_end got %0h want 0", bus0.redirect); end
    n_cmp++; if (bus0.ex_valid !== 1'b1 || bus1.ex_valid !== 1'b0) begin n_bad++;
      $display("FAIL bne_slot_ex got ds1=%0h ds0=%0h want 1/0", bus0.ex_valid, bus1.ex_valid); end
    cyc();
    cyc(); // slot instruction in WB
    n_cmp++; if (bus0.wb_valid !== 1'b1 || bus0.wb_rd !== 5'd5 || bus1.wb_valid !== 1'b0) begin
      n_bad++; $display("FAIL bne_slot_wb got ds1=%0h rd=%0d ds0=%0h want 1/5/0",
        bus0.wb_valid, bus0.wb_rd, bus1.wb_valid); end
    cyc();
    n_cmp++; if (bus0.retire_cnt !== 16'd2 || bus1.retire_cnt !== 2'd1) begin n_bad++;
      $display("FAIL bne_retire got %0d/%0d want 2/1", bus0.retire_cnt, bus1.retire_cnt); end
  endtask

  task automatic test_call_jmpl();
    do_reset();
    drive(1'b1, I_CALL, 1'b0, 1'b0);
    cyc();
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    n_cmp++; if (bus0.ex_call !== 1'b1 || bus0.ex_link !== 1'b1 || bus0.ex_rd !== 5'd15) begin
      n_bad++; $display("FAIL call_ex got c=%0h l=%0h rd=%0d want 1/1/15",
        bus0.ex_call, bus0.ex_link, bus0.ex_rd); end
    n_cmp++; if (bus0.redirect !== 1'b1) begin n_bad++;
      $display("FAIL call_redirect got %0h want 1", bus0.redirect); end
    cyc();
    n_cmp++; if (bus0.redirect !== 1'b0) begin n_bad++;
      $display("FAIL call_pulse_end got %0h want 0", bus0.redirect); end
    cyc();
    n_cmp++; if (bus0.wb_rd !== 5'd15 || bus0.wb_reg_write !== 1'b1) begin n_bad++;
      $display("FAIL call_wb got rd=%0d rw=%0h want 15/1", bus0.wb_rd, bus0.wb_reg_write); end
    drive(1'b1, I_JMPL, 1'b0, 1'b0);
    cyc();
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    n_cmp++; if (bus0.ex_jmpl !== 1'b1 || bus0.ex_rd !== 5'd9 || bus0.redirect !== 1'b1) begin
      n_bad++; $display("FAIL jmpl_ex got j=%0h rd=%0d rdr=%0h want 1/9/1",
        bus0.ex_jmpl, bus0.ex_rd, bus0.redirect); end
    cyc();
  endtask

  task automatic test_unknown();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, I_UNK, 1'b0, 1'b0);
      cyc();
    end
    n_cmp++; if (bus0.unk_cnt !== 16'd3 || bus1.unk_cnt !== 2'd3) begin n_bad++;
      $display("FAIL unk_three got %0d/%0d want 3/3", bus0.unk_cnt, bus1.unk_cnt); end
    n_cmp++; if (bus0.mem_write !== 1'b0 || bus0.mem_read !== 1'b0 ||
                 bus0.wb_reg_write !== 1'b0 || bus0.wb_valid !== 1'b1) begin n_bad++;
      $display("FAIL unk_no_write got mw=%0h mr=%0h rw=%0h wv=%0h want 0/0/0/1",
        bus0.mem_write, bus0.mem_read, bus0.wb_reg_write, bus0.wb_valid); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, I_UNK, 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    n_cmp++; if (bus0.unk_cnt !== 16'd5 || bus1.unk_cnt !== 2'd3) begin n_bad++;
      $display("FAIL unk_sat got %0d/%0d want 5/3", bus0.unk_cnt, bus1.unk_cnt); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    drive(1'b1, I_ADD, 1'b0, 1'b0);
    cyc();
    drive(1'b1, I_SETHI, 1'b0, 1'b0);
    cyc();
    drive(1'b1, I_BNE, 1'b0, 1'b0);
    cyc(); // bne EX, sethi MEM, add WB
    drive(1'b1, I_ADD, 1'b1, 1'b1);
    n_cmp++; if (bus0.redirect !== 1'b0 || bus0.id_ready !== 1'b0) begin n_bad++;
      $display("FAIL stall_hs got rdr=%0h rdy=%0h want 0/0", bus0.redirect, bus0.id_ready); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_cmp++; if (bus0.ex_branch !== 1'b1 || bus0.mem_rd !== 5'd6 || bus0.wb_rd !== 5'd5 ||
                   bus0.wb_valid !== 1'b1 || bus0.retire_cnt !== 16'd0 ||
                   bus0.redirect !== 1'b0) begin n_bad++;
        $display("FAIL stall_hold%0d got br=%0h mrd=%0d wrd=%0d wv=%0h rc=%0d rdr=%0h", i,
          bus0.ex_branch, bus0.mem_rd, bus0.wb_rd, bus0.wb_valid, bus0.retire_cnt,
          bus0.redirect);
        $display("  want 1/6/5/1/0/0"); end
    end
    drive(1'b1, I_ADD, 1'b0, 1'b1);
    n_cmp++; if (bus0.redirect !== 1'b1) begin n_bad++;
      $display("FAIL stall_release_rdr got %0h want 1", bus0.redirect); end
    cyc();
    n_cmp++; if (bus0.retire_cnt !== 16'd1 || bus0.wb_rd !== 5'd6 || bus0.ex_rd !== 5'd5 ||
                 bus1.ex_valid !== 1'b0) begin n_bad++;
      $display("FAIL stall_release got rc=%0d wrd=%0d erd=%0d ds0v=%0h want 1/6/5/0",
        bus0.retire_cnt, bus0.wb_rd, bus0.ex_rd, bus1.ex_valid); end
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    #2;
    reset = 1'b1; // between edges
    #1;
    n_cmp++; if (bus0.ex_valid !== 1'b0 || bus0.mem_valid !== 1'b0 || bus0.wb_valid !== 1'b0 ||
                 bus0.retire_cnt !== 16'd0 || bus0.ex_rd !== 5'd0 || bus0.wb_rd !== 5'd0) begin
      n_bad++; $display("FAIL async_reset got ev=%0h mv=%0h wv=%0h rc=%0d erd=%0d wrd=%0d",
        bus0.ex_valid, bus0.mem_valid, bus0.wb_valid, bus0.retire_cnt, bus0.ex_rd, bus0.wb_rd);
      end
    n_cmp++; if (bus0.id_ready !== 1'b1 || bus0.redirect !== 1'b0) begin n_bad++;
      $display("FAIL async_reset_hs got rdy=%0h rdr=%0h want 1/0", bus0.id_ready, bus0.redirect);
      end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, I_ADD, 1'b0, 1'b0);
    cyc();
    drive(1'b0, I_NOP, 1'b0, 1'b0);
    n_cmp++; if (bus0.ex_valid !== 1'b1 || bus0.ex_rd !== 5'd5) begin n_bad++;
      $display("FAIL post_reset_accept got v=%0h rd=%0d want 1/5", bus0.ex_valid, bus0.ex_rd); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    test_reset();
    test_stream();
    test_load_use();
    test_redirect();
    test_call_jmpl();
    test_unknown();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
